pwm_capture: RTL and testbench

- PWM receiver/decoder: measures an incoming PWM waveform and reports its high time (duty) and period, both counted in prescaler ticks.
- Uses the same prescaler tick timebase as the team's PWM generator. One generator period is 256 ticks, so `duty_o` reads back the generator's 8-bit duty setting directly.
- Sits on the input side of a PWM link or in a generator loopback for self-test.
- Reports a timeout when the line is static (duty 0 or full-high).

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_tick_gen.sv | 30 +++
 rtl/pwm_capture.sv | 144 ++++++++++++++
 tb/tb_pwm_capture.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared defaults and state type for the PWM capture path
package pwm_pkg;

  localparam int DVSR_DEF          = 10417;
  localparam int WIDTH_DEF         = 8;
  localparam int CNT_W_DEF         = 16;
  localparam int TIMEOUT_TICKS_DEF = 512;

  typedef enum logic [1:0] {
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

endpackage

// File: rtl/pwm_tick_gen.sv
// rtl/pwm_tick_gen.sv - free-running prescaler, one tick every DVSR+1 clocks
module pwm_tick_gen
  import pwm_pkg::*;
#(
  parameter int DVSR = DVSR_DEF
) (
  input  logic clk,
  input  logic rst_i,
  output logic tick
);

  localparam int            QW   = (DVSR > 0) ? $clog2(DVSR + 1) : 1;
  localparam logic [QW-1:0] TERM = QW'(DVSR);

  logic [QW-1:0] q;

  // Count 0..DVSR and wrap; the tick marks the zero state
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      q <= '0;
    end else if (q == TERM) begin
      q <= '0;
    end else begin
      q <= q + 1'b1;
    end
  end

  assign tick = (q == '0);

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM decoder reporting high time and period in prescaler ticks
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int DVSR          = DVSR_DEF,
  parameter int WIDTH         = WIDTH_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             pwm_i,
  output logic [WIDTH-1:0] duty_o,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             timeout_o
);

  localparam int               IW         = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [IW-1:0]    IDLE_LAST  = IW'(TIMEOUT_TICKS - 1);
  localparam logic [IW-1:0]    IDLE_MAX   = IW'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [WIDTH-1:0] DUTY_MAX   = '1;
  localparam logic [CNT_W-1:0] DUTY_MAX_W = CNT_W'(2 ** WIDTH - 1);

  logic tick;

  pwm_tick_gen #(.DVSR(DVSR)) u_tick (
    .clk  (clk),
    .rst_i(rst_i),
    .tick (tick)
  );

  logic s_meta, s, s_d;
  logic rise, fall, any_edge;

  // Two-flop synchronizer plus a delayed copy for edge detection
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
      s_d    <= 1'b0;
    end else begin
      s_meta <= pwm_i;
      s      <= s_meta;
      s_d    <= s;
    end
  end

  assign rise     = s & ~s_d;
  assign fall     = ~s & s_d;
  assign any_edge = rise | fall;

  logic [IW-1:0] idle_cnt;
  logic          idle_expire;

  // The expiry fires only on the tick that reaches the limit, so a static line pulses once
  assign idle_expire = tick && !any_edge && (idle_cnt == IDLE_LAST);

  // Ticks since the last edge, holding once the timeout limit is reached
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt <= '0;
    end else if (any_edge) begin
      idle_cnt <= '0;
    end else if (tick && (idle_cnt != IDLE_MAX)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] sat_duty(input logic [CNT_W-1:0] v);
    return (v > DUTY_MAX_W) ? DUTY_MAX : v[WIDTH-1:0];
  endfunction

  state_t           state;
  logic [CNT_W-1:0] hi_cnt, per_cnt, start_cnt;

  // A tick in the same cycle as a rise is the first tick of the new period
  assign start_cnt = {{(CNT_W-1){1'b0}}, tick};

  // Measurement FSM with registered result outputs
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state     <= WAIT_RISE;
      hi_cnt    <= '0;
      per_cnt   <= '0;
      duty_o    <= '0;
      period_o  <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (idle_expire) begin
        state     <= WAIT_RISE;
        hi_cnt    <= '0;
        per_cnt   <= '0;
        timeout_o <= 1'b1;
        duty_o    <= s ? DUTY_MAX : '0;
        period_o  <= '0;
        valid_o   <= 1'b1;
      end else begin
        case (state)
          WAIT_RISE: begin
            hi_cnt  <= '0;
            per_cnt <= '0;
            if (rise) begin
              state     <= MEAS_HIGH;
              hi_cnt    <= start_cnt;
              per_cnt   <= start_cnt;
              timeout_o <= 1'b0;
            end
          end
          MEAS_HIGH: begin
            if (fall) begin
              state <= MEAS_LOW;
              if (tick) per_cnt <= sat_inc(per_cnt);
            end else if (tick) begin
              hi_cnt  <= sat_inc(hi_cnt);
              per_cnt <= sat_inc(per_cnt);
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              duty_o   <= sat_duty(hi_cnt);
              period_o <= per_cnt;
              valid_o  <= 1'b1;
              state    <= MEAS_HIGH;
              hi_cnt   <= start_cnt;
              per_cnt  <= start_cnt;
            end else if (tick) begin
              per_cnt <= sat_inc(per_cnt);
            end
          end
          default: state <= WAIT_RISE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed bench for pwm_capture with DVSR=3
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        pwm_drv = 1'b0;
  logic        pwm_sel = 1'b0;
  logic        gen_rst = 1'b1;
  logic [7:0]  gen_duty = 8'd0;
  logic [7:0]  gen_cnt;
  logic        gen_tick, gen_pwm, pwm_line;

  logic [7:0]  duty_a, duty_b;
  logic [15:0] period_a;
  logic [7:0]  period_b;
  logic        valid_a, valid_b, timeout_a, timeout_b;

  int checks = 0;
  int errors = 0;
  int vcnt_a = 0, vcnt_b = 0;
  int ld_a = 0, lp_a = 0, ld_b = 0, lp_b = 0;

  always #5 clk = ~clk;

  assign gen_pwm  = (gen_cnt < gen_duty);
  assign pwm_line = pwm_sel ? gen_pwm : pwm_drv;

  pwm_capture #(.DVSR(3), .WIDTH(8), .CNT_W(16), .TIMEOUT_TICKS(512)) dut_a (
    .clk(clk), .rst_i(rst_i), .pwm_i(pwm_line),
    .duty_o(duty_a), .period_o(period_a), .valid_o(valid_a), .timeout_o(timeout_a)
  );

  pwm_capture #(.DVSR(3), .WIDTH(8), .CNT_W(8), .TIMEOUT_TICKS(512)) dut_b (
    .clk(clk), .rst_i(rst_i), .pwm_i(pwm_drv),
    .duty_o(duty_b), .period_o(period_b), .valid_o(valid_b), .timeout_o(timeout_b)
  );

  pwm_tick_gen #(.DVSR(3)) u_gen_tick (.clk(clk), .rst_i(gen_rst), .tick(gen_tick));

  always @(posedge clk) begin
    if (gen_rst) gen_cnt <= 8'd0;
    else if (gen_tick) gen_cnt <= gen_cnt + 8'd1;
  end

  always @(negedge clk) begin
    if (valid_a) begin
      vcnt_a <= vcnt_a + 1;
      ld_a   <= int'(duty_a);
      lp_a   <= int'(period_a);
    end
    if (valid_b) begin
      vcnt_b <= vcnt_b + 1;
      ld_b   <= int'(duty_b);
      lp_b   <= int'(period_b);
    end
  end

  typedef struct {
    int hi;
    int lo;
    int exp_duty;
    int exp_period;
    bit use_b;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_periods(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      pwm_drv = 1'b1;
      repeat (4 * hi) step();
      pwm_drv = 1'b0;
      repeat (4 * lo) step();
    end
  endtask

  task automatic wait_vcnt_a(input string name, input int target, input int budget);
    int k = 0;
    while (vcnt_a < target && k < budget) begin
      step();
      k++;
    end
    check(name, int'(vcnt_a >= target), 1);
  endtask

  task automatic wait_gen_cnt(input string name, input int target, input int budget);
    int k = 0;
    while (int'(gen_cnt) != target && k < budget) begin
      step();
      k++;
    end
    check(name, int'(gen_cnt), target);
  endtask

  initial begin
    int n, v, v2;

    vecs[0] = '{64, 192, 64, 256, 1'b0};
    vecs[1] = '{10, 20, 10, 30, 1'b0};
    vecs[2] = '{1, 1, 1, 2, 1'b0};
    vecs[3] = '{300, 10, 255, 310, 1'b0};
    vecs[4] = '{200, 100, 200, 255, 1'b1};
    vecs[5] = '{280, 20, 255, 255, 1'b1};
    vecs[6] = '{3, 250, 3, 253, 1'b0};

    // reset held with the input toggling
    for (int i = 0; i < 10; i++) begin
      pwm_drv = ~pwm_drv;
      step();
      check($sformatf("reset_outputs_%0d", i),
            int'(duty_a) + int'(period_a) + int'(valid_a) + int'(timeout_a), 0);
    end

    // table of steady waveforms, each from a fresh reset
    for (int i = 0; i < 7; i++) begin
      rst_i = 1'b1;
      pwm_drv = 1'b0;
      repeat (3) step();
      rst_i = 1'b0;
      step();
      v  = vcnt_a;
      v2 = vcnt_b;
      drive_periods(vecs[i].hi, vecs[i].lo, 3);
      repeat (8) step();
      if (vecs[i].use_b) begin
        check($sformatf("vec%0d_valid_count", i), vcnt_b - v2, 2);
        check($sformatf("vec%0d_duty", i), ld_b, vecs[i].exp_duty);
        check($sformatf("vec%0d_period", i), lp_b, vecs[i].exp_period);
      end else begin
        check($sformatf("vec%0d_valid_count", i), vcnt_a - v, 2);
        check($sformatf("vec%0d_duty", i), ld_a, vecs[i].exp_duty);
        check($sformatf("vec%0d_period", i), lp_a, vecs[i].exp_period);
      end
    end

    // low line from reset: timeout on the 512th tick
    rst_i = 1'b1;
    pwm_drv = 1'b0;
    repeat (5) step();
    rst_i = 1'b0;
    v = vcnt_a;
    n = 0;
    while (!valid_a && n < 3000) begin
      step();
      n++;
    end
    check("timeout_low_latency", n, 2045);
    check("timeout_low_duty", int'(duty_a), 0);
    check("timeout_low_period", int'(period_a), 0);
    check("timeout_low_flag", int'(timeout_a), 1);
    repeat (88 * 4) step();
    check("timeout_low_single_pulse", vcnt_a - v, 1);

    // recovery: flag holds until the rise reaches the FSM, then clears
    pwm_drv = 1'b1;
    repeat (2) step();
    check("timeout_before_rise", int'(timeout_a), 1);
    step();
    check("timeout_cleared_on_rise", int'(timeout_a), 0);
    repeat (37) step();
    pwm_drv = 1'b0;
    repeat (80) step();
    v = vcnt_a;
    pwm_drv = 1'b1;
    repeat (8) step();
    check("recover_valid_count", vcnt_a - v, 1);
    check("recover_duty", ld_a, 10);
    check("recover_period", lp_a, 30);

    // running 100/156 then held high
    drive_periods(100, 156, 2);
    pwm_drv = 1'b1;
    repeat (8) step();
    check("pre_high_duty", ld_a, 100);
    check("pre_high_period", lp_a, 256);
    v2 = vcnt_a;
    n = 8;
    while (!valid_a && n < 2600) begin
      step();
      n++;
    end
    check("timeout_high_latency_window", int'(n >= 2048 && n <= 2051), 1);
    check("timeout_high_duty", int'(duty_a), 255);
    check("timeout_high_period", int'(period_a), 0);
    check("timeout_high_flag", int'(timeout_a), 1);
    repeat (400) step();
    check("timeout_high_single_pulse", vcnt_a - v2, 1);
    pwm_drv = 1'b0;
    repeat (6) step();
    check("fall_in_wait_keeps_timeout", int'(timeout_a), 1);
    check("fall_in_wait_no_valid", vcnt_a - v2, 1);

    // loopback from an in-bench generator
    rst_i = 1'b1;
    gen_rst = 1'b1;
    pwm_sel = 1'b1;
    gen_duty = 8'd200;
    repeat (3) step();
    gen_rst = 1'b0;
    rst_i = 1'b0;
    v = vcnt_a;
    wait_vcnt_a("loop200_wait", v + 2, 4000);
    check("loop200_duty", ld_a, 200);
    check("loop200_period", lp_a, 256);

    // reset in the middle of the high phase, released in the low phase
    wait_gen_cnt("loop_wait_high", 100, 1200);
    rst_i = 1'b1;
    repeat (3) step();
    check("midreset_outputs",
          int'(duty_a) + int'(period_a) + int'(valid_a) + int'(timeout_a), 0);
    wait_gen_cnt("loop_wait_low", 220, 1200);
    rst_i = 1'b0;
    v = vcnt_a;
    wait_vcnt_a("midreset_wait", v + 1, 2000);
    check("midreset_duty", ld_a, 200);
    check("midreset_period", lp_a, 256);

    // duty change to 1: second valid after the change covers a full new period
    gen_duty = 8'd1;
    v = vcnt_a;
    wait_vcnt_a("loop1_wait", v + 2, 3000);
    check("loop1_duty", ld_a, 1);
    check("loop1_period", lp_a, 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
